ex_stage: RTL and testbench



---
 rtl/ex_stage.sv | 125 ++++++++++++
 tb/tb_ex_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: execute stage ALU with an optional radix-2 restoring divider.
// Define EX_DIV_EN to build the multi-cycle divide/modulo unit.
module ex_stage #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] reg1_i,
  input  logic [DW-1:0] reg2_i,
  input  logic [AW-1:0] waddr_i,
  input  logic          we_i,
  input  logic [2:0]    alusel_i,
  input  logic [7:0]    aluop_i,
  input  logic          flush_i,
  output logic [DW-1:0] wdata_o,
  output logic [AW-1:0] waddr_o,
  output logic          we_o,
  output logic          stallreq_o
);
  localparam logic [2:0] SEL_LOGIC = 3'b001, SEL_SHIFT = 3'b010, SEL_ARITH = 3'b100, SEL_DIV = 3'b110;
  localparam logic [7:0] OP_AND = 8'b00100100, OP_OR = 8'b00100101, OP_XOR = 8'b00100110,
                         OP_NOR = 8'b00100111, OP_LUI = 8'b01011100, OP_SLL = 8'b01111100,
                         OP_SRL = 8'b00000010, OP_SRA = 8'b00000011, OP_ADD = 8'b00100000,
                         OP_SUB = 8'b00100010, OP_SLT = 8'b00101010, OP_SLTU = 8'b00101011,
                         OP_DIV = 8'b00011010, OP_DIVU = 8'b00011011, OP_MOD = 8'b10011010,
                         OP_MODU = 8'b10011011;
  logic [DW-1:0] alu, div_res;
  logic          is_div, div_ok, stall;
  assign is_div = alusel_i == SEL_DIV;
  always_comb begin
    alu = '0;
    case (alusel_i)
      SEL_LOGIC:
        case (aluop_i)
          OP_OR:   alu = reg1_i | reg2_i;
          OP_AND:  alu = reg1_i & reg2_i;
          OP_XOR:  alu = reg1_i ^ reg2_i;
          OP_NOR:  alu = ~(reg1_i | reg2_i);
          OP_LUI:  alu = reg2_i;
          default: alu = '0;
        endcase
      SEL_SHIFT:
        case (aluop_i)
          OP_SLL:  alu = reg1_i << reg2_i[4:0];
          OP_SRL:  alu = reg1_i >> reg2_i[4:0];
          OP_SRA:  alu = $unsigned($signed(reg1_i) >>> reg2_i[4:0]);
          default: alu = '0;
        endcase
      SEL_ARITH:
        case (aluop_i)
          OP_ADD:  alu = reg1_i + reg2_i;
          OP_SUB:  alu = reg1_i - reg2_i;
          OP_SLT:  alu = DW'($signed(reg1_i) < $signed(reg2_i));
          OP_SLTU: alu = DW'(reg1_i < reg2_i);
          default: alu = '0;
        endcase
      default: alu = '0;
    endcase
  end
`ifdef EX_DIV_EN
  localparam int CW = $clog2(DW);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t        state;
  logic [DW-1:0] quo, rem, dvs, a_abs, b_abs, q_fin, r_fin;
  logic [CW-1:0] cnt;
  logic          neg_q, neg_r, sgn, a_neg, b_neg, b_zero;
  logic [DW:0]   trial, diff;
  assign sgn    = aluop_i == OP_DIV || aluop_i == OP_MOD;
  assign a_neg  = sgn & reg1_i[DW-1];
  assign b_neg  = sgn & reg2_i[DW-1];
  assign a_abs  = a_neg ? -reg1_i : reg1_i;
  assign b_abs  = b_neg ? -reg2_i : reg2_i;
  assign b_zero = reg2_i == '0;
  // Remainder stays below the divisor, so one extra bit holds the trial subtract.
  assign trial  = {rem, quo[DW-1]};
  assign diff   = trial - {1'b0, dvs};
  assign q_fin  = neg_q ? -quo : quo;
  assign r_fin  = neg_r ? -rem : rem;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (flush_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (is_div) begin
          state <= b_zero ? DONE : BUSY;
          cnt   <= '0;
          dvs   <= b_abs;
          quo   <= b_zero ? '1 : a_abs;
          rem   <= b_zero ? reg1_i : '0;
          neg_q <= !b_zero && (a_neg ^ b_neg);
          neg_r <= !b_zero && a_neg;
        end
        BUSY: begin
          quo <= {quo[DW-2:0], !diff[DW]};
          rem <= diff[DW] ? trial[DW-1:0] : diff[DW-1:0];
          cnt <= cnt + 1'b1;
          if (cnt == CW'(DW-1)) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  assign stall   = !flush_i && ((state == IDLE && is_div) || state == BUSY);
  assign div_ok  = state == DONE;
  assign div_res = !div_ok ? '0 : (aluop_i == OP_MOD || aluop_i == OP_MODU) ? r_fin : q_fin;
`else
  logic unused_clk;
  assign unused_clk = clk;
  assign stall      = 1'b0;
  assign div_ok     = 1'b0;
  assign div_res    = '0;
`endif
  assign stallreq_o = rst && stall;
  assign wdata_o    = !rst ? '0 : is_div ? div_res : alu;
  assign waddr_o    = rst ? waddr_i : '0;
  assign we_o       = rst && we_i && !stallreq_o && !flush_i && (!is_div || div_ok);
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: randomized check of ex_stage against an arithmetic reference model.
module tb_ex_stage;
  localparam logic [2:0] SEL_NOP = 3'b000, SEL_LOGIC = 3'b001, SEL_SHIFT = 3'b010,
                         SEL_ARITH = 3'b100, SEL_DIV = 3'b110;
  localparam logic [7:0] OP_AND = 8'b00100100, OP_OR = 8'b00100101, OP_XOR = 8'b00100110,
                         OP_NOR = 8'b00100111, OP_LUI = 8'b01011100, OP_SLL = 8'b01111100,
                         OP_SRL = 8'b00000010, OP_SRA = 8'b00000011, OP_ADD = 8'b00100000,
                         OP_SUB = 8'b00100010, OP_SLT = 8'b00101010, OP_SLTU = 8'b00101011,
                         OP_DIV = 8'b00011010, OP_DIVU = 8'b00011011, OP_MOD = 8'b10011010,
                         OP_MODU = 8'b10011011;
  logic        clk, rst, we_i, flush_i, we_o, stallreq_o;
  logic [31:0] reg1_i, reg2_i, wdata_o;
  logic [4:0]  waddr_i, waddr_o;
  logic [2:0]  alusel_i;
  logic [7:0]  aluop_i;
  int          checks = 0, errors = 0;
  logic [7:0]  ops[16] = '{OP_OR, OP_AND, OP_XOR, OP_NOR, OP_LUI, OP_SLL, OP_SRL, OP_SRA,
                           OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_DIV, OP_DIVU, OP_MOD, OP_MODU};

  ex_stage dut (
    .clk(clk), .rst(rst), .reg1_i(reg1_i), .reg2_i(reg2_i), .waddr_i(waddr_i), .we_i(we_i),
    .alusel_i(alusel_i), .aluop_i(aluop_i), .flush_i(flush_i), .wdata_o(wdata_o),
    .waddr_o(waddr_o), .we_o(we_o), .stallreq_o(stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] cls(input logic [7:0] op);
    case (op)
      OP_OR, OP_AND, OP_XOR, OP_NOR, OP_LUI: return SEL_LOGIC;
      OP_SLL, OP_SRL, OP_SRA:                return SEL_SHIFT;
      OP_ADD, OP_SUB, OP_SLT, OP_SLTU:       return SEL_ARITH;
      OP_DIV, OP_DIVU, OP_MOD, OP_MODU:      return SEL_DIV;
      default:                               return SEL_NOP;
    endcase
  endfunction

  function automatic logic [31:0] model(input logic [2:0] s, input logic [7:0] op,
                                        input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    if (s == SEL_NOP || s != cls(op)) return 32'h0;
`ifndef EX_DIV_EN
    if (s == SEL_DIV) return 32'h0;
`endif
    case (op)
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_LUI:  return b;
      OP_SLL:  return 32'(ua * (64'd1 << b[4:0]));
      OP_SRL:  return 32'(ua / (64'd1 << b[4:0]));
      OP_SRA:  return 32'(sa >>> b[4:0]);
      OP_ADD:  return 32'(ua + ub);
      OP_SUB:  return 32'(ua - ub);
      OP_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU: return (ua < ub) ? 32'd1 : 32'd0;
      OP_DIV:  return b == 0 ? 32'hFFFF_FFFF : 32'(sa / sb);
      OP_MOD:  return b == 0 ? a : 32'(sa % sb);
      OP_DIVU: return b == 0 ? 32'hFFFF_FFFF : 32'(ua / ub);
      OP_MODU: return b == 0 ? a : 32'(ua % ub);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] rnd_val();
    logic [31:0] corner[5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    case ($urandom_range(0, 3))
      0:       return corner[$urandom_range(0, 4)];
      1:       return 32'($urandom_range(0, 16)) - 32'd8;
      default: return $urandom;
    endcase
  endfunction

  // Single-cycle op: drive at posedge+1, sample 1ns later, advance one clock.
  task automatic alu_chk(input string tag, input logic [2:0] s, input logic [7:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    logic [4:0] wa;
    logic       w;
    wa = 5'($urandom);
    w  = 1'($urandom);
    alusel_i = s; aluop_i = op; reg1_i = a; reg2_i = b; waddr_i = wa; we_i = w;
    #1;
    check({tag, "_data"}, wdata_o, model(s, op, a, b));
    check({tag, "_we"}, 32'(we_o), 32'(w && s != SEL_DIV));
    check({tag, "_stall"}, 32'(stallreq_o), 32'd0);
    check({tag, "_waddr"}, 32'(waddr_o), 32'(wa));
    @(posedge clk); #1;
  endtask

`ifdef EX_DIV_EN
  // Divide from IDLE: counts stall cycles, then checks the DONE-cycle outputs.
  task automatic do_div(input string tag, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit scr);
    int          n;
    logic [31:0] e;
    logic [4:0]  wa;
    n  = 0;
    e  = model(SEL_DIV, op, a, b);
    wa = 5'($urandom);
    alusel_i = SEL_DIV; aluop_i = op; reg1_i = a; reg2_i = b; waddr_i = wa; we_i = 1'b1;
    @(negedge clk);
    while (stallreq_o && n < 40) begin
      n++;
      if (!we_o === 1'b0) check({tag, "_we_stall"}, 32'(we_o), 32'd0);
      if (scr && n >= 2) begin reg1_i = $urandom; reg2_i = $urandom; end
      @(negedge clk);
    end
    check({tag, "_stall_cycles"}, 32'(n), b == 0 ? 32'd1 : 32'd33);
    check({tag, "_data"}, wdata_o, e);
    check({tag, "_we"}, 32'(we_o), 32'd1);
    check({tag, "_waddr"}, 32'(waddr_o), 32'(wa));
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    rst = 1'b0; flush_i = 1'b0; we_i = 1'b1; waddr_i = 5'd5;
    alusel_i = SEL_ARITH; aluop_i = OP_ADD; reg1_i = 32'd3; reg2_i = 32'd4;
    #12;
    check("rst_stall", 32'(stallreq_o), 32'd0);
    check("rst_wdata", wdata_o, 32'd0);
    check("rst_we", 32'(we_o), 32'd0);
    check("rst_waddr", 32'(waddr_o), 32'd0);
    alusel_i = SEL_DIV; aluop_i = OP_DIV;
    #1;
    check("rst_div_stall", 32'(stallreq_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    alusel_i = SEL_NOP;
    @(posedge clk); #1;
    alu_chk("add_ovf", SEL_ARITH, OP_ADD, 32'h7FFF_FFFF, 32'd1);
    alu_chk("sra", SEL_SHIFT, OP_SRA, 32'h8000_0000, 32'd4);
    alu_chk("slt", SEL_ARITH, OP_SLT, 32'hFFFF_FFFF, 32'd1);
    alu_chk("sltu", SEL_ARITH, OP_SLTU, 32'hFFFF_FFFF, 32'd1);
    alu_chk("nop", SEL_NOP, OP_ADD, 32'd5, 32'd6);
    for (int i = 0; i < 80; i++) begin
      logic [7:0] op;
`ifdef EX_DIV_EN
      op = ops[$urandom_range(0, 11)];
`else
      op = ops[$urandom_range(0, 15)];
`endif
      alu_chk("rnd", $urandom_range(0, 7) == 0 ? SEL_NOP : cls(op), op, rnd_val(), rnd_val());
    end
`ifdef EX_DIV_EN
    do_div("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_div("mod_m7_2", OP_MOD, 32'hFFFF_FFF9, 32'd2, 1'b1);
    do_div("divu_z", OP_DIVU, 32'd100, 32'd0, 1'b0);
    do_div("modu_z", OP_MODU, 32'd100, 32'd0, 1'b0);
    do_div("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_div("mod_ovf", OP_MOD, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    alusel_i = SEL_DIV; aluop_i = OP_DIV; reg1_i = 32'hFFFF_FF9C; reg2_i = 32'd7; we_i = 1'b1;
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    #1;
    check("flush_stall", 32'(stallreq_o), 32'd0);
    check("flush_we", 32'(we_o), 32'd0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    do_div("divu_9_3", OP_DIVU, 32'd9, 32'd3, 1'b0);
    alusel_i = SEL_DIV; aluop_i = OP_DIVU; reg1_i = 32'd1000; reg2_i = 32'd3;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_stall", 32'(stallreq_o), 32'd0);
    check("rst_mid_we", 32'(we_o), 32'd0);
    check("rst_mid_wdata", wdata_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_idle_restart", 32'(stallreq_o), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    do_div("after_rst", OP_DIVU, 32'd1000, 32'd3, 1'b0);
    for (int i = 0; i < 12; i++) begin
      logic [31:0] b;
      b = $urandom_range(0, 5) == 0 ? 32'd0 : rnd_val();
      do_div("div_rnd", ops[12 + $urandom_range(0, 3)], rnd_val(), b, 1'($urandom));
    end
    alusel_i = SEL_NOP;
    @(posedge clk); #1;
    alu_chk("post_div", SEL_LOGIC, OP_XOR, 32'hA5A5_0000, 32'h0F0F_FFFF);
`else
    alu_chk("div_off", SEL_DIV, OP_DIV, 32'd6, 32'd3);
    alu_chk("modu_off", SEL_DIV, OP_MODU, 32'd100, 32'd0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
